isa_io_target: RTL
==================

Name: isa_io_target

Overview:
- ISA-bus I/O responder. It sits on the card side of the ISA slot that the host-side strobe generator drives.
- Watches the asynchronous nIOR/nIOW strobes and decodes SA against a base window.
- Bridges each matching cycle to a local register-bank handshake (rd/wr/ack). Drives SD with read data and stretches the cycle through IOCHRDY until the bank answers.
- All logic runs on one clock; bus inputs are synchronised internally.

Parameters:
- BASE_ADDR, 10'h300, I/O base; compared on SA[9:REG_BITS].
- REG_BITS, 3, log2 of registers in window (window = 2**REG_BITS bytes).
- WR_SETTLE, 2, clk cycles to wait after write-strobe detection before sampling SD_in (range 1..15).
- TIMEOUT, 64, max clk cycles waiting for reg_ack before forced completion (range 2..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- nIOR  in  1  ISA I/O read strobe, async, active low
- nIOW  in  1  ISA I/O write strobe, async, active low
- SA  in  10  ISA address, stable before strobe falls
- SD_in  in  8  ISA data bus input
- SD_out  out  8  read data to ISA data bus
- SD_oe  out  1  1 = drive SD_out onto bus
- iochrdy_pull  out  1  1 = pull IOCHRDY low (wait state)
- reg_addr  out  REG_BITS  register offset, SA[REG_BITS-1:0] latched
- reg_wdata  out  8  write data to bank
- reg_rd  out  1  one-cycle read request
- reg_wr  out  1  one-cycle write request
- reg_rdata  in  8  bank read data, valid with reg_ack
- reg_ack  in  1  bank completion, one cycle
- timeout  out  1  one-cycle pulse when TIMEOUT expires

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: SD_out=8'h00, SD_oe=0, iochrdy_pull=0, reg_addr=0, reg_wdata=0, reg_rd=0, reg_wr=0, timeout=0, state=IDLE, synchronisers=1.
- Synchroniser: 2-flop chain per strobe (ior_s, iow_s), plus one history flop each.
- Strobe detection: a strobe is detected when its synced value goes 1->0 while state=IDLE. Pin fall to detection takes 2-3 clk.
- Detection cycle actions:
  - SA sampled directly.
  - match = (SA[9:REG_BITS] == BASE_ADDR[9:REG_BITS]).
  - reg_addr <= SA[REG_BITS-1:0] on match.
- States and transitions:
  - IDLE:
    - ior detected, iow_s=1, match -> RD_REQ.
    - iow detected, ior_s=1, match -> WR_SETTLE.
    - Any detection with no match, or both strobes synced low -> DONE, with no bus outputs asserted.
  - RD_REQ (1 cycle): reg_rd=1, iochrdy_pull=1, counter cleared -> RD_WAIT.
  - RD_WAIT:
    - iochrdy_pull=1; counter increments each cycle.
    - reg_ack=1 -> SD_out<=reg_rdata, SD_oe<=1, iochrdy_pull<=0 -> RD_HOLD.
    - counter reaches TIMEOUT-1 first -> SD_out<=8'hFF, SD_oe<=1, iochrdy_pull<=0, timeout pulse -> RD_HOLD.
  - RD_HOLD: SD_oe held while ior_s=0. On ior_s=1, SD_oe<=0 -> IDLE.
  - WR_SETTLE:
    - iochrdy_pull=1; counts WR_SETTLE cycles.
    - On final count: reg_wdata<=SD_in, reg_wr=1 for one cycle -> WR_WAIT.
  - WR_WAIT: iochrdy_pull=1; reg_ack or timeout (same rule as RD_WAIT, timeout pulse) -> iochrdy_pull<=0 -> DONE.
  - DONE: all bus outputs inactive; wait until ior_s=1 and iow_s=1 -> IDLE.
- reg_ack timing: accepted in the same cycle as reg_rd/reg_wr or any later cycle. reg_ack in IDLE/DONE/RD_HOLD is ignored.
- Strobe released mid-wait (synced strobe returns 1 in RD_REQ/RD_WAIT/WR_SETTLE/WR_WAIT):
  - Abort: iochrdy_pull<=0, SD_oe stays 0.
  - Go to IDLE next cycle; no timeout pulse.
  - A reg_ack arriving later is ignored.
- Reset asserted mid-cycle: next clk returns all outputs to reset values and state to IDLE. A strobe still held low is not re-detected, because there is no 1->0 edge.
- Single-cycle guarantees:
  - reg_rd, reg_wr and timeout are each high for exactly one cycle per bus transaction.
  - Never more than one request is issued per strobe assertion.
- SD_oe and iochrdy_pull are never both 1 in the same cycle.

Test Plan:
- Matched read: SA=10'h302, nIOR low for 20 cycles, bank acks 3 cycles after reg_rd with 8'hA5 -> reg_addr=2, one reg_rd pulse, iochrdy_pull high until ack, SD_out=8'hA5 with SD_oe=1 until 1 cycle after synced nIOR rise.
- Matched write: SA=10'h307, SD_in=8'h3C, nIOW low, ack 1 cycle after reg_wr -> reg_wr fires exactly WR_SETTLE cycles after detection, reg_addr=7, reg_wdata=8'h3C, SD_oe never asserted.
- Address miss: SA=10'h2F8, nIOR then nIOW strobes -> no reg_rd/reg_wr, SD_oe=0, iochrdy_pull=0 throughout.
- Timeout: matched read, reg_ack never asserted -> timeout pulse after TIMEOUT cycles in RD_WAIT, SD_out=8'hFF, iochrdy_pull released.
- Abort and collision:
  - nIOR released during RD_WAIT -> iochrdy_pull drops, IDLE, late reg_ack ignored.
  - nIOR and nIOW low together -> no request issued; DONE until both high.
- Reset mid-operation: reset pulsed in WR_WAIT with nIOW still low -> outputs at reset values, no further reg_wr until nIOW rises and falls again.

Source files
------------

// File: rtl/isa_io_target.sv
// -----------------------------------------------------------------------------
// isa_io_target
//
// Card-side ISA I/O responder. The host's nIOR/nIOW strobes are synchronised
// into the clk domain. A falling synced strobe seen in IDLE is checked against
// the I/O window at BASE_ADDR. A matching access becomes a one-cycle request
// to the local register bank. IOCHRDY is held low until the bank answers, or
// until TIMEOUT cycles pass. Read data is driven on SD until the host releases
// nIOR.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   nIOR, nIOW    ISA I/O strobes (asynchronous, active low)
//   SA            ISA address, stable before a strobe falls
//   SD_in         ISA data bus input
//   SD_out        read data for the ISA data bus
//   SD_oe         1 = drive SD_out onto the bus
//   iochrdy_pull  1 = pull IOCHRDY low (insert wait states)
//   reg_addr      register offset inside the window
//   reg_wdata     write data to the bank
//   reg_rd        one-cycle read request to the bank
//   reg_wr        one-cycle write request to the bank
//   reg_rdata     bank read data, valid with reg_ack
//   reg_ack       one-cycle bank completion
//   timeout       one-cycle pulse when the bank failed to answer in time
// -----------------------------------------------------------------------------
module isa_io_target #(
    parameter logic [9:0]  BASE_ADDR = 10'h300,
    parameter int unsigned REG_BITS  = 3,
    parameter int unsigned WR_SETTLE = 2,   // 1..15
    parameter int unsigned TIMEOUT   = 64   // 2..255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nIOR,
    input  logic                nIOW,
    input  logic [9:0]          SA,
    input  logic [7:0]          SD_in,
    output logic [7:0]          SD_out,
    output logic                SD_oe,
    output logic                iochrdy_pull,
    output logic [REG_BITS-1:0] reg_addr,
    output logic [7:0]          reg_wdata,
    output logic                reg_rd,
    output logic                reg_wr,
    input  logic [7:0]          reg_rdata,
    input  logic                reg_ack,
    output logic                timeout
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_REQ    = 3'd1;
    localparam logic [2:0] ST_RD_WAIT   = 3'd2;
    localparam logic [2:0] ST_RD_HOLD   = 3'd3;
    localparam logic [2:0] ST_WR_SETTLE = 3'd4;
    localparam logic [2:0] ST_WR_WAIT   = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    localparam logic [7:0] TO_LAST     = 8'(TIMEOUT - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(WR_SETTLE - 1);

    // Strobe synchronisers: meta -> synced (_s) -> history (_h).
    logic ior_meta_q, ior_s_q, ior_h_q;
    logic iow_meta_q, iow_s_q, iow_h_q;

    // The chain resets to 1, so right after reset a strobe already held low
    // would look like a fresh 1->0 edge. Edges are qualified until the history
    // flop holds a value that really came from the pin.
    logic [2:0] sync_vld_q;

    logic [2:0]          state_q,     state_d;
    logic [7:0]          cnt_q,       cnt_d;
    logic [7:0]          sd_out_q,    sd_out_d;
    logic                sd_oe_q,     sd_oe_d;
    logic                pull_q,      pull_d;
    logic [REG_BITS-1:0] reg_addr_q,  reg_addr_d;
    logic [7:0]          reg_wdata_q, reg_wdata_d;
    logic                reg_rd_q,    reg_rd_d;
    logic                reg_wr_q,    reg_wr_d;
    logic                timeout_q,   timeout_d;

    logic ior_fall, iow_fall, addr_match;

    assign ior_fall   = sync_vld_q[2] & ior_h_q & ~ior_s_q;
    assign iow_fall   = sync_vld_q[2] & iow_h_q & ~iow_s_q;
    assign addr_match = (SA[9:REG_BITS] == BASE_ADDR[9:REG_BITS]);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            ior_meta_q <= 1'b1;
            ior_s_q    <= 1'b1;
            ior_h_q    <= 1'b1;
            iow_meta_q <= 1'b1;
            iow_s_q    <= 1'b1;
            iow_h_q    <= 1'b1;
            sync_vld_q <= '0;
        end else begin
            ior_meta_q <= nIOR;
            ior_s_q    <= ior_meta_q;
            ior_h_q    <= ior_s_q;
            iow_meta_q <= nIOW;
            iow_s_q    <= iow_meta_q;
            iow_h_q    <= iow_s_q;
            sync_vld_q <= {sync_vld_q[1:0], 1'b1};
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default here so no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        sd_out_d    = sd_out_q;
        sd_oe_d     = sd_oe_q;
        pull_d      = pull_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_rd_d    = 1'b0;
        reg_wr_d    = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ior_fall || iow_fall) begin
                    if (addr_match) begin
                        reg_addr_d = SA[REG_BITS-1:0];
                    end
                    // A read needs nIOW idle and vice versa; both low is a
                    // collision and is parked in DONE with no request.
                    if (ior_fall && iow_s_q && addr_match) begin
                        state_d  = ST_RD_REQ;
                        reg_rd_d = 1'b1;
                        pull_d   = 1'b1;
                    end else if (iow_fall && ior_s_q && addr_match) begin
                        state_d = ST_WR_SETTLE;
                        pull_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            // reg_rd is high during this state; an ack here is accepted too.
            ST_RD_REQ: begin
                if (ior_s_q) begin
                    pull_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (reg_ack) begin
                    sd_out_d = reg_rdata;
                    sd_oe_d  = 1'b1;
                    pull_d   = 1'b0;
                    state_d  = ST_RD_HOLD;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (ior_s_q) begin
                    pull_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (reg_ack) begin
                    sd_out_d = reg_rdata;
                    sd_oe_d  = 1'b1;
                    pull_d   = 1'b0;
                    state_d  = ST_RD_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    // Bank never answered: finish the bus cycle with all-ones.
                    sd_out_d  = 8'hFF;
                    sd_oe_d   = 1'b1;
                    pull_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_RD_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_RD_HOLD: begin
                if (ior_s_q) begin
                    sd_oe_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            // SD is only sampled after the host has had WR_SETTLE cycles to
            // settle the bus following strobe detection.
            ST_WR_SETTLE: begin
                if (iow_s_q) begin
                    pull_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    reg_wdata_d = SD_in;
                    reg_wr_d    = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_WR_WAIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_WR_WAIT: begin
                if (iow_s_q) begin
                    pull_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (reg_ack) begin
                    pull_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    pull_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                if (ior_s_q && iow_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                pull_d  = 1'b0;
                sd_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sd_out_q    <= 8'h00;
            sd_oe_q     <= 1'b0;
            pull_q      <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= 8'h00;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sd_out_q    <= sd_out_d;
            sd_oe_q     <= sd_oe_d;
            pull_q      <= pull_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            timeout_q   <= timeout_d;
        end
    end

    assign SD_out       = sd_out_q;
    assign SD_oe        = sd_oe_q;
    assign iochrdy_pull = pull_q;
    assign reg_addr     = reg_addr_q;
    assign reg_wdata    = reg_wdata_q;
    assign reg_rd       = reg_rd_q;
    assign reg_wr       = reg_wr_q;
    assign timeout      = timeout_q;

endmodule
